// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its environment:
// the CPU MEM-stage port, the external loader/debug port and the memory macro.
interface dmem_arbiter_if;
   // CPU MEM-stage port
   logic        cpu_read;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   // External loader/debug port
   logic        ext_req;
   logic        ext_we;
   logic [15:0] ext_addr;
   logic [15:0] ext_wdata;
   logic        ext_gnt;
   logic [15:0] ext_rdata;
   logic        ext_rvalid;
   // Memory macro port
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_rdata;
   // Debug
   logic [1:0]  owner;

   // Arbiter side
   modport slave (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata,
      output owner
   );

   // Environment side (pipeline, external port and memory)
   modport master (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata,
      input  owner
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage has priority, the external
// port is guaranteed a grant after STARVE_MAX consecutive denied cycles.
// Reads hold the memory for MEM_LAT cycles; writes complete in the issue cycle.
module dmem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic           clock,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      EXT_RD = 2'd2
   } state_t;

   localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [15:0] cpu_rdata_q, cpu_rdata_d;
   logic [15:0] ext_rdata_q, ext_rdata_d;

   logic        cpu_win;
   logic        ext_win;
   logic        cpu_done;
   logic        ext_done;

   // Arbitration, read tracking and next-state; nothing is active while reset is low
   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      cpu_rdata_d  = cpu_rdata_q;
      ext_rdata_d  = ext_rdata_q;
      cpu_win      = 1'b0;
      ext_win      = 1'b0;
      cpu_done     = 1'b0;
      ext_done     = 1'b0;

      if (reset) begin
         case (state_q)
            IDLE: begin
               if (bus.ext_req && (starve_cnt_q == STARVE_LIM)) begin
                  ext_win = 1'b1;
               end else if (bus.cpu_read || bus.cpu_write) begin
                  cpu_win = 1'b1;
               end else if (bus.ext_req) begin
                  ext_win = 1'b1;
               end
               // A simultaneous read+write from the CPU is a write
               if (cpu_win && !bus.cpu_write) begin
                  state_d   = CPU_RD;
                  lat_cnt_d = LAT_INIT;
               end
               if (ext_win && !bus.ext_we) begin
                  state_d   = EXT_RD;
                  lat_cnt_d = LAT_INIT;
               end
            end
            CPU_RD: begin
               lat_cnt_d = lat_cnt_q - 2'd1;
               if (lat_cnt_q == 2'd1) begin
                  cpu_done    = 1'b1;
                  cpu_rdata_d = bus.mem_rdata;
                  state_d     = IDLE;
               end
            end
            EXT_RD: begin
               lat_cnt_d = lat_cnt_q - 2'd1;
               if (lat_cnt_q == 2'd1) begin
                  ext_done    = 1'b1;
                  ext_rdata_d = bus.mem_rdata;
                  state_d     = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               lat_cnt_d = 2'd0;
            end
         endcase

         // Dropping ext_req before a grant freezes the count rather than clearing it
         if (ext_win) begin
            starve_cnt_d = 4'd0;
         end else if (bus.ext_req && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
   end

   // Memory steering, handshakes and debug owner; the loser never reaches memory
   always_comb begin
      bus.mem_addr   = 16'h0000;
      bus.mem_wdata  = 16'h0000;
      bus.mem_we     = 1'b0;
      bus.mem_re     = 1'b0;
      bus.ext_gnt    = ext_win;
      bus.ext_rvalid = ext_done;
      bus.cpu_stall  = 1'b0;
      bus.owner      = 2'b00;

      if (cpu_win) begin
         bus.mem_addr = bus.cpu_addr;
         if (bus.cpu_write) begin
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = 1'b1;
         end else begin
            bus.mem_re = 1'b1;
         end
      end else if (ext_win) begin
         bus.mem_addr = bus.ext_addr;
         if (bus.ext_we) begin
            bus.mem_wdata = bus.ext_wdata;
            bus.mem_we    = 1'b1;
         end else begin
            bus.mem_re = 1'b1;
         end
      end

      if (reset) begin
         bus.cpu_stall = (bus.cpu_read || bus.cpu_write)
                         && !(cpu_win && bus.cpu_write)
                         && !cpu_done;
      end

      if (cpu_win || (state_q == CPU_RD)) begin
         bus.owner = 2'b01;
      end else if (ext_win || (state_q == EXT_RD)) begin
         bus.owner = 2'b10;
      end
   end

   // Read data is forwarded in its completion cycle, then held from the capture register
   always_comb begin
      bus.cpu_rdata = cpu_done ? bus.mem_rdata : cpu_rdata_q;
      bus.ext_rdata = ext_done ? bus.mem_rdata : ext_rdata_q;
   end

   // State, latency, starvation and read-data registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 2'd0;
         starve_cnt_q <= 4'd0;
         cpu_rdata_q  <= 16'h0000;
         ext_rdata_q  <= 16'h0000;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ext_rdata_q  <= ext_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=2 and one with
// MEM_LAT=3 (both STARVE_MAX=4), each backed by a small latency-accurate memory.
module tb_dmem_arbiter;

   logic clock;
   logic reset;

   int total;
   int bad;

   dmem_arbiter_if ifa ();
   dmem_arbiter_if ifb ();

   dmem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (ifa)
   );

   dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (ifb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory models: data appears on mem_rdata exactly MEM_LAT cycles after mem_re
   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   logic [15:0] pa [0:2];
   logic [15:0] pb [0:2];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;

   always @(posedge clock) begin
      if (pre_we) mem_a[pre_addr] <= pre_data;
      else if (ifa.mem_we) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
      pa[0] <= ifa.mem_re ? mem_a[ifa.mem_addr[7:0]] : 16'h0000;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
   end

   always @(posedge clock) begin
      if (ifb.mem_we) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
      pb[0] <= ifb.mem_re ? mem_b[ifb.mem_addr[7:0]] : 16'h0000;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end

   assign ifa.mem_rdata = pa[1];
   assign ifb.mem_rdata = pb[2];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   // Uncontended CPU read on the MEM_LAT=2 instance: two stall cycles, data with stall low
   task automatic cpu_rd_a(input logic [15:0] a, input logic [15:0] d);
      tick();
      ifa.cpu_read = 1'b1;
      ifa.cpu_addr = a;
      settle();
      chk("rd_c0_stall", ifa.cpu_stall, 16'd1);
      chk("rd_c0_re", ifa.mem_re, 16'd1);
      chk("rd_c0_addr", ifa.mem_addr, a);
      chk("rd_c0_owner", ifa.owner, 16'd1);
      tick();
      settle();
      chk("rd_c1_stall", ifa.cpu_stall, 16'd1);
      chk("rd_c1_re", ifa.mem_re, 16'd0);
      chk("rd_c1_owner", ifa.owner, 16'd1);
      tick();
      settle();
      chk("rd_c2_stall", ifa.cpu_stall, 16'd0);
      chk("rd_c2_data", ifa.cpu_rdata, d);
      chk("rd_c2_owner", ifa.owner, 16'd1);
      tick();
      ifa.cpu_read = 1'b0;
      settle();
      chk("rd_c3_owner", ifa.owner, 16'd0);
      chk("rd_c3_hold", ifa.cpu_rdata, d);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      pre_we = 1'b1;
      pre_addr = 8'h10;
      pre_data = 16'hBEEF;
      ifa.cpu_read = 1'b0; ifa.cpu_write = 1'b0; ifa.cpu_addr = 16'h0; ifa.cpu_wdata = 16'h0;
      ifa.ext_req = 1'b0;  ifa.ext_we = 1'b0;    ifa.ext_addr = 16'h0; ifa.ext_wdata = 16'h0;
      ifb.cpu_read = 1'b0; ifb.cpu_write = 1'b0; ifb.cpu_addr = 16'h0; ifb.cpu_wdata = 16'h0;
      ifb.ext_req = 1'b0;  ifb.ext_we = 1'b0;    ifb.ext_addr = 16'h0; ifb.ext_wdata = 16'h0;

      // Held in reset with requests asserted: every output stays 0
      tick();
      pre_we = 1'b0;
      ifa.cpu_read = 1'b1;
      ifa.cpu_addr = 16'h0010;
      ifa.ext_req  = 1'b1;
      settle();
      chk("rst_re", ifa.mem_re, 16'd0);
      chk("rst_addr", ifa.mem_addr, 16'h0000);
      chk("rst_stall", ifa.cpu_stall, 16'd0);
      chk("rst_gnt", ifa.ext_gnt, 16'd0);
      chk("rst_owner", ifa.owner, 16'd0);
      chk("rst_cpu_rdata", ifa.cpu_rdata, 16'h0000);
      chk("rst_starve", u_dut_a.starve_cnt_q, 16'd0);
      tick();
      ifa.cpu_read = 1'b0;
      ifa.ext_req  = 1'b0;
      reset = 1'b1;
      settle();

      // CPU read after reset release
      cpu_rd_a(16'h0010, 16'hBEEF);

      // Back-to-back CPU writes, then read both back
      tick();
      ifa.cpu_write = 1'b1;
      ifa.cpu_addr  = 16'h0020;
      ifa.cpu_wdata = 16'h1234;
      settle();
      chk("wr0_we", ifa.mem_we, 16'd1);
      chk("wr0_data", ifa.mem_wdata, 16'h1234);
      chk("wr0_stall", ifa.cpu_stall, 16'd0);
      tick();
      ifa.cpu_addr  = 16'h0022;
      ifa.cpu_wdata = 16'h5678;
      settle();
      chk("wr1_we", ifa.mem_we, 16'd1);
      chk("wr1_addr", ifa.mem_addr, 16'h0022);
      chk("wr1_stall", ifa.cpu_stall, 16'd0);
      tick();
      ifa.cpu_write = 1'b0;
      settle();
      cpu_rd_a(16'h0020, 16'h1234);
      cpu_rd_a(16'h0022, 16'h5678);

      // External write starved by continuous CPU writes
      tick();
      ifa.ext_req   = 1'b1;
      ifa.ext_we    = 1'b1;
      ifa.ext_addr  = 16'h0030;
      ifa.ext_wdata = 16'hAAAA;
      ifa.cpu_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ifa.cpu_addr  = 16'h0040 + 16'(i);
         ifa.cpu_wdata = 16'h0100 + 16'(i);
         settle();
         chk("stv_starve", u_dut_a.starve_cnt_q, 16'(i));
         chk("stv_cpu_addr", ifa.mem_addr, 16'h0040 + 16'(i));
         chk("stv_cpu_we", ifa.mem_we, 16'd1);
         chk("stv_gnt0", ifa.ext_gnt, 16'd0);
         chk("stv_stall0", ifa.cpu_stall, 16'd0);
         tick();
      end
      ifa.cpu_addr  = 16'h0044;
      ifa.cpu_wdata = 16'h0104;
      settle();
      chk("stv_gnt", ifa.ext_gnt, 16'd1);
      chk("stv_ext_addr", ifa.mem_addr, 16'h0030);
      chk("stv_ext_data", ifa.mem_wdata, 16'hAAAA);
      chk("stv_stall", ifa.cpu_stall, 16'd1);
      chk("stv_owner", ifa.owner, 16'd2);
      tick();
      ifa.ext_req = 1'b0;
      settle();
      chk("stv_after_starve", u_dut_a.starve_cnt_q, 16'd0);
      chk("stv_after_gnt", ifa.ext_gnt, 16'd0);
      chk("stv_after_addr", ifa.mem_addr, 16'h0044);
      chk("stv_after_stall", ifa.cpu_stall, 16'd0);
      tick();
      ifa.cpu_write = 1'b0;
      settle();

      // Read+write together against a waiting external read: CPU write wins
      tick();
      ifa.cpu_read  = 1'b1;
      ifa.cpu_write = 1'b1;
      ifa.cpu_addr  = 16'h0050;
      ifa.cpu_wdata = 16'h9999;
      ifa.ext_req   = 1'b1;
      ifa.ext_we    = 1'b0;
      ifa.ext_addr  = 16'h0030;
      settle();
      chk("rw_we", ifa.mem_we, 16'd1);
      chk("rw_re", ifa.mem_re, 16'd0);
      chk("rw_gnt", ifa.ext_gnt, 16'd0);
      chk("rw_stall", ifa.cpu_stall, 16'd0);
      tick();
      ifa.cpu_read  = 1'b0;
      ifa.cpu_write = 1'b0;
      settle();
      chk("rw_starve", u_dut_a.starve_cnt_q, 16'd1);
      chk("exa_gnt", ifa.ext_gnt, 16'd1);
      chk("exa_re", ifa.mem_re, 16'd1);
      chk("exa_owner", ifa.owner, 16'd2);
      tick();
      ifa.ext_req = 1'b0;
      settle();
      chk("exa_c1_rvalid", ifa.ext_rvalid, 16'd0);
      chk("exa_c1_owner", ifa.owner, 16'd2);
      tick();
      settle();
      chk("exa_c2_rvalid", ifa.ext_rvalid, 16'd1);
      chk("exa_c2_data", ifa.ext_rdata, 16'hAAAA);
      cpu_rd_a(16'h0050, 16'h9999);

      // MEM_LAT=3 instance: external write, then external read with a CPU read behind it
      tick();
      ifb.ext_req   = 1'b1;
      ifb.ext_we    = 1'b1;
      ifb.ext_addr  = 16'h0030;
      ifb.ext_wdata = 16'hAAAA;
      settle();
      chk("b_wr_gnt", ifb.ext_gnt, 16'd1);
      chk("b_wr_we", ifb.mem_we, 16'd1);
      tick();
      ifb.ext_we = 1'b0;
      settle();
      chk("b_t0_gnt", ifb.ext_gnt, 16'd1);
      chk("b_t0_re", ifb.mem_re, 16'd1);
      tick();
      ifb.ext_req  = 1'b0;
      ifb.cpu_read = 1'b1;
      ifb.cpu_addr = 16'h0030;
      settle();
      chk("b_t1_rvalid", ifb.ext_rvalid, 16'd0);
      chk("b_t1_stall", ifb.cpu_stall, 16'd1);
      chk("b_t1_re", ifb.mem_re, 16'd0);
      chk("b_t1_owner", ifb.owner, 16'd2);
      tick();
      settle();
      chk("b_t2_rvalid", ifb.ext_rvalid, 16'd0);
      tick();
      settle();
      chk("b_t3_rvalid", ifb.ext_rvalid, 16'd1);
      chk("b_t3_data", ifb.ext_rdata, 16'hAAAA);
      chk("b_t3_re", ifb.mem_re, 16'd0);
      tick();
      settle();
      chk("b_t4_re", ifb.mem_re, 16'd1);
      chk("b_t4_owner", ifb.owner, 16'd1);
      chk("b_t4_rvalid", ifb.ext_rvalid, 16'd0);
      chk("b_t4_hold", ifb.ext_rdata, 16'hAAAA);
      tick();
      settle();
      chk("b_t5_stall", ifb.cpu_stall, 16'd1);
      tick();
      settle();
      chk("b_t6_stall", ifb.cpu_stall, 16'd1);
      tick();
      settle();
      chk("b_t7_stall", ifb.cpu_stall, 16'd0);
      chk("b_t7_data", ifb.cpu_rdata, 16'hAAAA);
      tick();
      ifb.cpu_read = 1'b0;
      settle();

      // Reset in the completion cycle of a CPU read abandons it
      tick();
      ifa.cpu_read = 1'b1;
      ifa.cpu_addr = 16'h0010;
      settle();
      tick();
      settle();
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", ifa.cpu_stall, 16'd0);
      chk("mid_rst_owner", ifa.owner, 16'd0);
      chk("mid_rst_cpu_rdata", ifa.cpu_rdata, 16'h0000);
      chk("mid_rst_ext_rdata", ifa.ext_rdata, 16'h0000);
      chk("mid_rst_re", ifa.mem_re, 16'd0);
      settle();
      tick();
      reset = 1'b1;
      ifa.cpu_read = 1'b0;
      settle();
      chk("post_rst_stall", ifa.cpu_stall, 16'd0);
      chk("post_rst_owner", ifa.owner, 16'd0);
      chk("post_rst_rdata", ifa.cpu_rdata, 16'h0000);
      chk("post_rst_rvalid", ifa.ext_rvalid, 16'd0);
      cpu_rd_a(16'h0010, 16'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
